act_skew_feeder: RTL and testbench

Activation skew feeder for the systolic array. It buffers one tile of activation vectors through a valid/ready handshake, then streams them into the array's row inputs (the `a_in` of each leftmost MAC) with row r delayed by r cycles. The diagonal wavefront lines up each activation with the weight-stationary psum chain. It sits directly upstream of the MAC grid's west edge.

---
 rtl/act_skew_feeder.sv | 149 ++++++++++++++
 tb/tb_act_skew_feeder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/act_skew_feeder.sv
//------------------------------------------------------------------------------
// Module   : act_skew_feeder
// Summary  : Buffers one tile of activation vectors, then streams them into the
//            array rows with row r delayed by r cycles (zero-filled diagonal).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module act_skew_feeder #(
    parameter int bit_width = 8,
    parameter int ROWS      = 4,
    parameter int DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*bit_width-1:0] in_data,
    input  logic                      in_last,
    output logic [ROWS*bit_width-1:0] a_row,
    output logic                      a_valid,
    output logic                      tile_done,
    output logic                      busy
);

    localparam int c_W  = ROWS * bit_width;
    localparam int c_CW = $clog2(DEPTH + ROWS + 1);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CW-1:0] c_ROWS_M1  = c_CW'(ROWS - 1);
    localparam logic [c_CW-1:0] c_DEPTH_M1 = c_CW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [c_CW-1:0]   k_q, k_d;
    logic [c_CW-1:0]   t_q, t_d;
    logic [c_W-1:0]    buf_q [DEPTH];

    logic              in_ready_q, in_ready_d;
    logic [c_W-1:0]    a_row_q, a_row_d;
    logic              a_valid_q, a_valid_d;
    logic              tile_done_q, tile_done_d;
    logic              busy_q, busy_d;

    logic              w_accept;
    logic              w_terminal;
    logic [c_CW-1:0]   w_last_t_q;
    logic [c_CW-1:0]   w_last_t_d;

    assign w_accept   = in_valid && in_ready_q;
    assign w_terminal = in_last || (k_q == c_DEPTH_M1);
    assign w_last_t_q = k_q + c_ROWS_M1 - c_ONE;
    assign w_last_t_d = k_d + c_ROWS_M1 - c_ONE;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (w_accept) begin
                    k_d     = k_q + c_ONE;
                    t_d     = '0;
                    state_d = w_terminal ? S_STREAM : S_LOAD;
                end
            end
            S_STREAM: begin
                if (t_q == w_last_t_q) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                    t_d     = '0;
                end else begin
                    t_d = t_q + c_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
                t_d     = '0;
            end
        endcase
    end

    // Outputs are computed from next-state values so they can be registered;
    // the beat being written this edge is bypassed since buf_q lags by one cycle.
    always_comb begin
        int idx;
        idx         = 0;
        in_ready_d  = (state_d != S_STREAM);
        busy_d      = (state_d != S_IDLE);
        a_valid_d   = (state_d == S_STREAM);
        tile_done_d = (state_d == S_STREAM) && (t_d == w_last_t_d);
        a_row_d     = '0;
        if (state_d == S_STREAM) begin
            for (int r = 0; r < ROWS; r++) begin
                idx = int'(t_d) - r;
                if (idx >= 0 && idx < int'(k_d)) begin
                    if (w_accept && int'(k_q) == idx) begin
                        a_row_d[r*bit_width +: bit_width] = in_data[r*bit_width +: bit_width];
                    end else begin
                        a_row_d[r*bit_width +: bit_width] = buf_q[idx[c_AW-1:0]][r*bit_width +: bit_width];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            t_q         <= '0;
            in_ready_q  <= 1'b1;
            a_row_q     <= '0;
            a_valid_q   <= 1'b0;
            tile_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            t_q         <= t_d;
            in_ready_q  <= in_ready_d;
            a_row_q     <= a_row_d;
            a_valid_q   <= a_valid_d;
            tile_done_q <= tile_done_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            buf_q[k_q[c_AW-1:0]] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign a_row     = a_row_q;
    assign a_valid   = a_valid_q;
    assign tile_done = tile_done_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_act_skew_feeder.sv
//------------------------------------------------------------------------------
// Module   : tb_act_skew_feeder
// Summary  : Directed table-driven bench for act_skew_feeder (ROWS=4, DEPTH=8).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_act_skew_feeder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] a_row;
    logic        a_valid;
    logic        tile_done;
    logic        busy;

    int n_chk;
    int n_fail;

    act_skew_feeder #(
        .bit_width(8),
        .ROWS     (4),
        .DEPTH    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .a_row    (a_row),
        .a_valid  (a_valid),
        .tile_done(tile_done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic [31:0] ea;
        logic        av;
        logic        dn;
        logic        bz;
        logic        rd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [31:0] ea, input logic av,
                           input logic dn, input logic bz, input logic rd);
        chk32({nm, " a_row"}, a_row, ea);
        chk1({nm, " a_valid"}, a_valid, av);
        chk1({nm, " tile_done"}, tile_done, dn);
        chk1({nm, " busy"}, busy, bz);
        chk1({nm, " in_ready"}, in_ready, rd);
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic l,
                       input logic [31:0] ea, input logic av, input logic dn,
                       input logic bz, input logic rd);
        vec_t e;
        e.v = v; e.d = d; e.l = l; e.ea = ea; e.av = av; e.dn = dn; e.bz = bz; e.rd = rd;
        tbl.push_back(e);
    endtask

    task automatic add_load(input logic v, input logic [31:0] d, input logic l);
        add(v, d, l, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic add_str(input logic v, input logic [31:0] d, input logic l,
                           input logic [31:0] ea, input logic dn);
        add(v, d, l, ea, 1'b1, dn, 1'b1, 1'b0);
    endtask

    task automatic add_idle(input logic v, input logic [31:0] d, input logic l);
        add(v, d, l, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    // Full-buffer tile: beat j, element r = 16*j + r + 1
    function automatic logic [31:0] fb_beat(input int j);
        logic [31:0] b;
        b = '0;
        for (int r = 0; r < 4; r++) b[r*8 +: 8] = 8'(16*j + r + 1);
        return b;
    endfunction

    function automatic logic [31:0] fb_exp(input int t);
        logic [31:0] b;
        b = '0;
        for (int r = 0; r < 4; r++)
            if (t - r >= 0 && t - r < 8) b[r*8 +: 8] = 8'(16*(t - r) + r + 1);
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;

        // Nominal K=3 tile with valid stalls; garbage in_last on a stalled cycle
        add_load(1'b1, 32'h03020100, 1'b0);
        add_load(1'b0, 32'hDEADBEEF, 1'b1);
        add_load(1'b1, 32'h13121110, 1'b0);
        add_load(1'b0, 32'h00000000, 1'b0);
        add_str (1'b1, 32'h23222120, 1'b1, 32'h00000000, 1'b0);
        add_str (1'b1, 32'hFFFFFFFF, 1'b1, 32'h00000110, 1'b0);
        add_str (1'b1, 32'hFFFFFFFF, 1'b1, 32'h00021120, 1'b0);
        add_str (1'b1, 32'hFFFFFFFF, 1'b1, 32'h03122100, 1'b0);
        add_str (1'b1, 32'hFFFFFFFF, 1'b1, 32'h13220000, 1'b0);
        add_str (1'b1, 32'hFFFFFFFF, 1'b1, 32'h23000000, 1'b1);
        add_idle(1'b1, 32'hFFFFFFFF, 1'b1);
        // Back-to-back single-vector tile accepted at the IDLE edge
        add_str (1'b1, 32'h44332211, 1'b1, 32'h00000011, 1'b0);
        add_str (1'b0, 32'h00000000, 1'b0, 32'h00002200, 1'b0);
        add_str (1'b0, 32'h00000000, 1'b0, 32'h00330000, 1'b0);
        add_str (1'b0, 32'h00000000, 1'b0, 32'h44000000, 1'b1);
        add_idle(1'b0, 32'h00000000, 1'b0);
        // Full buffer without in_last: 8 beats then 11 stream cycles
        for (int j = 0; j < 7; j++) add_load(1'b1, fb_beat(j), 1'b0);
        add_str(1'b1, fb_beat(7), 1'b0, fb_exp(0), 1'b0);
        for (int t = 1; t <= 10; t++) add_str(1'b1, 32'hFFFFFFFF, 1'b0, fb_exp(t), (t == 10));
        add_idle(1'b0, 32'h00000000, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l);
            chk_out($sformatf("vec%0d", i), tbl[i].ea, tbl[i].av, tbl[i].dn, tbl[i].bz, tbl[i].rd);
        end

        // Asynchronous reset at t=2 of a nominal tile
        drive(1'b1, 32'h03020100, 1'b0);
        drive(1'b1, 32'h13121110, 1'b0);
        drive(1'b1, 32'h23222120, 1'b1);
        drive(1'b0, 32'h00000000, 1'b0);
        drive(1'b0, 32'h00000000, 1'b0);
        chk_out("pre-reset t2", 32'h00021120, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // K=1 tile after reset
        drive(1'b1, 32'h44332211, 1'b1);
        chk_out("post-reset t0", 32'h00000011, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h00000000, 1'b0);
        chk_out("post-reset t1", 32'h00002200, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h00000000, 1'b0);
        chk_out("post-reset t2", 32'h00330000, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h00000000, 1'b0);
        chk_out("post-reset t3", 32'h44000000, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 32'h00000000, 1'b0);
        chk_out("post-reset idle", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
